// File: rtl/fx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fx_arb
//  Description : Two-master round-robin arbiter/sequencer for the fx register
//                bus. Define FX_ARB_FIXPRI_EN for fixed priority (master 0).
//  Revision    : 1.0  initial release
// ============================================================================
module fx_arb #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_rnw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rnw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] fx_waddr,
    output logic              fx_wr,
    output logic [DATA_W-1:0] fx_data,
    output logic [ADDR_W-1:0] fx_raddr,
    output logic              fx_rd,
    input  logic [DATA_W-1:0] fx_q,
    output logic              busy,
    output logic              gnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_cmd_rnw;

    logic                w_req_any;
    logic                w_sel;
    logic                w_rnw;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    always_comb begin
        w_req_any = m0_req | m1_req;
`ifdef FX_ARB_FIXPRI_EN
        w_sel     = ~m0_req;
`else
        w_sel     = (m0_req & m1_req) ? ~gnt : m1_req;
`endif
        w_rnw     = w_sel ? m1_rnw   : m0_rnw;
        w_addr    = w_sel ? m1_addr  : m0_addr;
        w_wdata   = w_sel ? m1_wdata : m0_wdata;
    end

    // Bus address/data/strobe are loaded on the grant edge so they are
    // visible during ISSUE; the address/data registers double as the command.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cmd_rnw <= 1'b0;
            gnt       <= 1'b1;
            busy      <= 1'b0;
            fx_wr     <= 1'b0;
            fx_rd     <= 1'b0;
            fx_waddr  <= '0;
            fx_raddr  <= '0;
            fx_data   <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        gnt       <= w_sel;
                        r_cmd_rnw <= w_rnw;
                        fx_waddr  <= w_addr;
                        fx_raddr  <= w_addr;
                        fx_data   <= w_wdata;
                        fx_wr     <= ~w_rnw;
                        fx_rd     <= w_rnw;
                        busy      <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    fx_wr <= 1'b0;
                    fx_rd <= 1'b0;
                    if (r_cmd_rnw) begin
                        r_state <= S_CAPT;
                    end else begin
                        m0_ack  <= ~gnt;
                        m1_ack  <= gnt;
                        r_state <= S_DONE;
                    end
                end
                S_CAPT: begin
                    if (gnt) begin
                        m1_rdata <= fx_q;
                    end else begin
                        m0_rdata <= fx_q;
                    end
                    m0_ack  <= ~gnt;
                    m1_ack  <= gnt;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fx_arb.sv
`default_nettype none
// Testbench for fx_arb: randomized commands from both masters checked against
// a transaction-level memory/readback model and a bench register slave.
module tb_fx_arb;

`ifdef FX_ARB_FIXPRI_EN
    localparam bit FIXPRI = 1'b1;
`else
    localparam bit FIXPRI = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_rnw, m1_req, m1_rnw;
    logic [21:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [21:0] fx_waddr, fx_raddr;
    logic        fx_wr, fx_rd;
    logic [7:0]  fx_data, fx_q;
    logic        busy, gnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_sys = ~clk_sys;

    fx_arb #(.ADDR_W(22), .DATA_W(8)) dut (
        .clk_sys (clk_sys),  .rst_n   (rst_n),
        .m0_req  (m0_req),   .m0_rnw  (m0_rnw),   .m0_addr (m0_addr),
        .m0_wdata(m0_wdata), .m0_ack  (m0_ack),   .m0_rdata(m0_rdata),
        .m1_req  (m1_req),   .m1_rnw  (m1_rnw),   .m1_addr (m1_addr),
        .m1_wdata(m1_wdata), .m1_ack  (m1_ack),   .m1_rdata(m1_rdata),
        .fx_waddr(fx_waddr), .fx_wr   (fx_wr),    .fx_data (fx_data),
        .fx_raddr(fx_raddr), .fx_rd   (fx_rd),    .fx_q    (fx_q),
        .busy    (busy),     .gnt     (gnt)
    );

    // Bench slave: device 0x01, offsets 0x0000-0x00FF, data one cycle after fx_rd
    function automatic bit slv_hit(input logic [21:0] a);
        return a[21:8] == 14'h0100;
    endfunction

    logic [7:0] slv_mem [256];
    always @(posedge clk_sys) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= 8'h00;
            fx_q <= 8'h00;
        end else begin
            if (fx_wr && slv_hit(fx_waddr)) slv_mem[fx_waddr[7:0]] <= fx_data;
            fx_q <= (fx_rd && slv_hit(fx_raddr)) ? slv_mem[fx_raddr[7:0]] : 8'h00;
        end
    end

    // Reference model: slave contents and each master's last returned read data
    logic [7:0] model_mem [256];
    logic [7:0] model_rd  [2];

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
    endtask

    task automatic model_apply(input int m, input bit rnw, input logic [21:0] a, input logic [7:0] d);
        if (!rnw) begin
            if (slv_hit(a)) model_mem[a[7:0]] = d;
        end else begin
            model_rd[m] = slv_hit(a) ? model_mem[a[7:0]] : 8'h00;
        end
    endtask

    typedef struct {
        int          lat;
        int          scyc;
        int          nwr;
        int          nrd;
        int          nack;
        int          nack_other;
        logic [21:0] sa;
        logic [7:0]  sd;
        logic [7:0]  rd;
        logic [7:0]  ord;
    } obs_t;

    // Issue one command from master m and observe the bus and acks for 12 cycles
    // counted from the grant edge. Address/data are scrambled after the grant.
    task automatic run_cmd(input int m, input bit rnw, input logic [21:0] addr,
                           input logic [7:0] wd, input bit drop, output obs_t o);
        int w;
        o = '{lat: -1, scyc: -1, nwr: 0, nrd: 0, nack: 0, nack_other: 0,
              sa: '0, sd: '0, rd: '0, ord: '0};
        w = 0;
        while (busy && w < 20) begin
            @(posedge clk_sys); #1;
            w++;
        end
        if (m == 0) begin
            m0_rnw = rnw; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            m1_rnw = rnw; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk_sys); #1;
            if (c == 1) begin
                if (m == 0) begin
                    m0_addr = 22'($urandom); m0_wdata = 8'($urandom);
                    if (drop) m0_req = 1'b0;
                end else begin
                    m1_addr = 22'($urandom); m1_wdata = 8'($urandom);
                    if (drop) m1_req = 1'b0;
                end
            end
            if (fx_wr) begin o.nwr++; o.sa = fx_waddr; o.sd = fx_data; o.scyc = c; end
            if (fx_rd) begin o.nrd++; o.sa = fx_raddr; o.scyc = c; end
            if ((m == 0) ? m0_ack : m1_ack) begin
                o.nack++;
                if (o.lat < 0) begin
                    o.lat = c;
                    o.rd  = (m == 0) ? m0_rdata : m1_rdata;
                    o.ord = (m == 0) ? m1_rdata : m0_rdata;
                end
                if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
            end
            if ((m == 0) ? m1_ack : m0_ack) o.nack_other++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk_sys); #1; end
        model_reset();
        n_total++; if ({busy, fx_wr, fx_rd, m0_ack, m1_ack} !== 5'b0)
            $display("FAIL rst_ctrl: got %b want 00000", {busy, fx_wr, fx_rd, m0_ack, m1_ack}); else n_pass++;
        n_total++; if (gnt !== 1'b1) $display("FAIL rst_gnt: got %b want 1", gnt); else n_pass++;
        n_total++; if ({fx_waddr, fx_raddr, fx_data} !== 52'h0)
            $display("FAIL rst_bus: got %h %h %h want 0", fx_waddr, fx_raddr, fx_data); else n_pass++;
        n_total++; if ({m0_rdata, m1_rdata} !== 16'h0)
            $display("FAIL rst_rdata: got %h %h want 0", m0_rdata, m1_rdata); else n_pass++;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk_sys); #1; end
        n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_write_m0();
        obs_t o;
        run_cmd(0, 1'b0, 22'h01_0081, 8'h5A, 1'b0, o);
        model_apply(0, 1'b0, 22'h01_0081, 8'h5A);
        n_total++; if (o.lat !== 2) $display("FAIL wr_ack_lat: got %0d want 2", o.lat); else n_pass++;
        n_total++; if (o.scyc !== 1 || o.nwr !== 1 || o.nrd !== 0)
            $display("FAIL wr_strobe: got cyc %0d wr %0d rd %0d want 1 1 0", o.scyc, o.nwr, o.nrd); else n_pass++;
        n_total++; if (o.sa !== 22'h01_0081 || o.sd !== 8'h5A)
            $display("FAIL wr_addr_data: got %h/%h want 010081/5a", o.sa, o.sd); else n_pass++;
        n_total++; if (o.rd !== model_rd[0]) $display("FAIL wr_rdata_kept: got %h want %h", o.rd, model_rd[0]); else n_pass++;
        n_total++; if (o.nack !== 1 || o.nack_other !== 0)
            $display("FAIL wr_acks: got %0d/%0d want 1/0", o.nack, o.nack_other); else n_pass++;
    endtask

    task automatic test_read_m1();
        obs_t o;
        run_cmd(1, 1'b1, 22'h01_0081, 8'h33, 1'b0, o);
        model_apply(1, 1'b1, 22'h01_0081, 8'h33);
        n_total++; if (o.lat !== 3) $display("FAIL rd_ack_lat: got %0d want 3", o.lat); else n_pass++;
        n_total++; if (o.rd !== 8'h5A) $display("FAIL rd_data: got %h want 5a", o.rd); else n_pass++;
        n_total++; if (o.ord !== model_rd[0]) $display("FAIL rd_other_kept: got %h want %h", o.ord, model_rd[0]); else n_pass++;
        n_total++; if (o.scyc !== 1 || o.nrd !== 1 || o.nwr !== 0 || o.sa !== 22'h01_0081)
            $display("FAIL rd_strobe: got cyc %0d rd %0d wr %0d a %h", o.scyc, o.nrd, o.nwr, o.sa); else n_pass++;
    endtask

    task automatic test_unmapped();
        obs_t o;
        run_cmd(0, 1'b1, 22'h01_0081, 8'h00, 1'b0, o);
        model_apply(0, 1'b1, 22'h01_0081, 8'h00);
        n_total++; if (o.rd !== model_rd[0]) $display("FAIL map_rd: got %h want %h", o.rd, model_rd[0]); else n_pass++;
        run_cmd(0, 1'b1, 22'h3F_1234, 8'h00, 1'b0, o);
        model_apply(0, 1'b1, 22'h3F_1234, 8'h00);
        n_total++; if (o.rd !== 8'h00) $display("FAIL unmap_rd: got %h want 00", o.rd); else n_pass++;
        n_total++; if (o.nack !== 1 || o.lat !== 3)
            $display("FAIL unmap_ack: got n %0d lat %0d want 1 3", o.nack, o.lat); else n_pass++;
    endtask

    task automatic test_req_drop();
        obs_t o;
        logic [7:0] d;
        d = 8'($urandom);
        run_cmd(0, 1'b0, 22'h01_0010, d, 1'b1, o);
        model_apply(0, 1'b0, 22'h01_0010, d);
        n_total++; if (o.nack !== 1 || o.lat !== 2)
            $display("FAIL drop_ack: got n %0d lat %0d want 1 2", o.nack, o.lat); else n_pass++;
        n_total++; if (o.nwr !== 1 || o.nrd !== 0 || o.sd !== d)
            $display("FAIL drop_bus: got wr %0d rd %0d d %h want 1 0 %h", o.nwr, o.nrd, o.sd, d); else n_pass++;
        run_cmd(1, 1'b1, 22'h01_0010, 8'h00, 1'b0, o);
        model_apply(1, 1'b1, 22'h01_0010, 8'h00);
        n_total++; if (o.rd !== d) $display("FAIL drop_readback: got %h want %h", o.rd, d); else n_pass++;
    endtask

    task automatic test_contention();
        int seq[$];
        int gseq[$];
        int both = 0;
        int e;
        rst_n = 1'b0;
        m0_rnw = 1'b0; m0_addr = 22'h01_0020; m0_wdata = 8'hA0; m0_req = 1'b1;
        m1_rnw = 1'b0; m1_addr = 22'h01_0021; m1_wdata = 8'hB1; m1_req = 1'b1;
        repeat (2) begin @(posedge clk_sys); #1; end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_sys); #1;
            if (m0_ack) begin seq.push_back(0); gseq.push_back(int'(gnt)); end
            if (m1_ack) begin seq.push_back(1); gseq.push_back(int'(gnt)); end
            if (m0_ack && m1_ack) both++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) begin @(posedge clk_sys); #1; end
        model_reset();
        model_apply(0, 1'b0, 22'h01_0020, 8'hA0);
        if (!FIXPRI) model_apply(1, 1'b0, 22'h01_0021, 8'hB1);
        n_total++; if (seq.size() < 8) $display("FAIL arb_count: got %0d want >=8", seq.size()); else n_pass++;
        n_total++; if (both !== 0) $display("FAIL arb_both_ack: got %0d want 0", both); else n_pass++;
        for (int k = 0; k < 8 && k < seq.size(); k++) begin
            e = FIXPRI ? 0 : (k % 2);
            n_total++; if (seq[k] !== e || gseq[k] !== e)
                $display("FAIL arb_order[%0d]: got m%0d gnt %0d want %0d", k, seq[k], gseq[k], e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int w;
        w = 0;
        while (busy && w < 20) begin @(posedge clk_sys); #1; w++; end
        m0_rnw = 1'b1; m0_addr = 22'h01_0020; m0_req = 1'b1;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        n_total++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy); else n_pass++;
        rst_n = 1'b0; m0_req = 1'b0;
        @(posedge clk_sys); #1;
        model_reset();
        n_total++; if ({busy, fx_wr, fx_rd, m0_ack, m1_ack, gnt} !== 6'b000001)
            $display("FAIL rmid_ctrl: got %b want 000001", {busy, fx_wr, fx_rd, m0_ack, m1_ack, gnt}); else n_pass++;
        n_total++; if ({fx_waddr, fx_raddr, fx_data, m0_rdata, m1_rdata} !== 68'h0)
            $display("FAIL rmid_data: got %h %h %h %h %h want 0", fx_waddr, fx_raddr, fx_data, m0_rdata, m1_rdata); else n_pass++;
        rst_n = 1'b1;
        w = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_sys); #1;
            if (m0_ack || m1_ack || busy) w++;
        end
        n_total++; if (w !== 0) $display("FAIL rmid_no_ack: got %0d active cycles want 0", w); else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        int m;
        bit rnw;
        logic [21:0] a;
        logic [7:0] d, exp_rd, exp_ord;
        int bad;
        for (int i = 0; i < 40; i++) begin
            m   = int'($urandom_range(0, 1));
            rnw = 1'($urandom);
            a   = ($urandom_range(0, 3) != 0) ? (22'h01_0000 | 22'($urandom_range(0, 15))) : 22'($urandom);
            d   = 8'($urandom);
            run_cmd(m, rnw, a, d, 1'b0, o);
            model_apply(m, rnw, a, d);
            exp_rd  = model_rd[m];
            exp_ord = model_rd[1 - m];
            bad = 0;
            if (o.lat !== (rnw ? 3 : 2) || o.nack !== 1 || o.nack_other !== 0) bad = 1;
            if (o.nwr !== int'(!rnw) || o.nrd !== int'(rnw) || o.sa !== a || o.scyc !== 1) bad = bad + 2;
            if (!rnw && o.sd !== d) bad = bad + 4;
            n_total++; if (bad !== 0)
                $display("FAIL rand_bus[%0d]: got code %0d lat %0d a %h want 0 for m%0d rnw %0d a %h", i, bad, o.lat, o.sa, m, rnw, a); else n_pass++;
            n_total++; if (o.rd !== exp_rd || o.ord !== exp_ord)
                $display("FAIL rand_rdata[%0d]: got %h/%h want %h/%h", i, o.rd, o.ord, exp_rd, exp_ord); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m0_rnw = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_rnw = 1'b0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_write_m0();
        test_read_m1();
        test_unmapped();
        test_req_drop();
        test_contention();
        test_random();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
